// File: rtl/shifter_seq_ctrl.sv
// shifter_seq_ctrl: 32-bit multi-cycle barrel shifter, one power-of-two
// stage per SHIFT cycle, valid/ready on both input and output sides.
module shifter_seq_ctrl #(
  parameter bit FAST_ZERO = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        SH_DIR,
  input  logic [4:0]  SH_AMT,
  input  logic [31:0] D_IN,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] D_OUT,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_k;
  logic        r_dir;
  logic [4:0]  r_amt;
  logic [31:0] r_work;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;

  logic [4:0]  w_dist;
  logic        w_take;
  logic [31:0] w_left;
  logic [31:0] w_right;
  logic [31:0] w_next;

  // Current stage: distance 2^k, applied only if bit k of the amount is set
  always_comb begin
    w_dist  = 5'b00001 << r_k;
    w_take  = |(r_amt & w_dist);
    w_left  = r_work << w_dist;
    w_right = $signed(r_work) >>> w_dist;
    w_next  = r_work;
    if (w_take) begin
      w_next = r_dir ? w_right : w_left;
    end
  end

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_k         <= 3'd0;
      r_dir       <= 1'b0;
      r_amt       <= 5'd0;
      r_work      <= 32'h0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (IN_VALID) begin
            r_work     <= D_IN;
            r_dir      <= SH_DIR;
            r_amt      <= SH_AMT;
            r_k        <= 3'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (FAST_ZERO && (SH_AMT == 5'd0)) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_next;
          r_k    <= r_k + 3'd1;
          if (r_k == 3'd4) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign BUSY      = r_busy;
  assign D_OUT     = r_work;

endmodule

// File: tb/tb_shifter_seq_ctrl.sv
// tb_shifter_seq_ctrl: scoreboard bench for shifter_seq_ctrl,
// normal-latency instance plus a FAST_ZERO instance.
module tb_shifter_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sh_dir;
  logic [4:0]  sh_amt;
  logic [31:0] d_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d_out;
  logic        busy;

  logic        z_in_valid;
  logic        z_in_ready;
  logic        z_out_valid;
  logic        z_out_ready;
  logic [31:0] z_d_out;
  logic        z_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  shifter_seq_ctrl #(.FAST_ZERO(1'b0)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .SH_DIR    (sh_dir),
    .SH_AMT    (sh_amt),
    .D_IN      (d_in),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .D_OUT     (d_out),
    .BUSY      (busy)
  );

  shifter_seq_ctrl #(.FAST_ZERO(1'b1)) dut_fz (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (z_in_valid),
    .IN_READY  (z_in_ready),
    .SH_DIR    (sh_dir),
    .SH_AMT    (sh_amt),
    .D_IN      (d_in),
    .OUT_VALID (z_out_valid),
    .OUT_READY (z_out_ready),
    .D_OUT     (z_d_out),
    .BUSY      (z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic dir,
                                        input logic [4:0] amt,
                                        input logic [31:0] din);
    if (dir) return $signed(din) >>> amt;
    return din << amt;
  endfunction

  task automatic scramble();
    sh_dir = 1'($urandom);
    sh_amt = 5'($urandom);
    d_in   = $urandom;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!in_ready && g < 20) begin
      tick();
      g++;
    end
    if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic wait_done(input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      scramble();
    end
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic issue(input logic dir, input logic [4:0] amt,
                       input logic [31:0] din);
    wait_ready();
    in_valid = 1'b1;
    sh_dir   = dir;
    sh_amt   = amt;
    d_in     = din;
    sb.push_back(model(dir, amt, din));
    tick();
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      check(tag, d_out, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic dir,
                         input logic [4:0] amt, input logic [31:0] din,
                         input int hold);
    logic [31:0] held;
    issue(dir, amt, din);
    wait_done(5);
    held = d_out;
    pop_check(tag);
    repeat (hold) tick();
    if (hold > 0) check({tag, "_hold"}, d_out, held);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {29'd0, out_valid, busy, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int zl;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    z_in_valid  = 1'b0;
    z_out_ready = 1'b0;
    sh_dir      = 1'b0;
    sh_amt      = 5'd0;
    d_in        = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_status", {29'd0, out_valid, busy, in_ready}, 32'd1);
    check("rst_dout", d_out, 32'h0);

    run_req("left31", 1'b0, 5'd31, 32'h0000_0001, 0);
    check("left31_val", model(1'b0, 5'd31, 32'h1), 32'h8000_0000);
    run_req("asr4", 1'b1, 5'd4, 32'h8000_0000, 1);
    run_req("asr31", 1'b1, 5'd31, 32'h7FFF_FFFF, 0);
    run_req("asr31n", 1'b1, 5'd31, 32'h8000_0001, 0);
    run_req("zero_slow", 1'b0, 5'd0, 32'hDEAD_BEEF, 0);

    // backpressure: stall in DONE while a new request is offered
    issue(1'b0, 5'd8, 32'h1234_5678);
    wait_done(5);
    held = d_out;
    pop_check("bp_res");
    in_valid = 1'b1;
    sh_dir   = 1'b1;
    sh_amt   = 5'd3;
    d_in     = 32'hF000_0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_dout", d_out, held);
      check("bp_flags", {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {29'd0, out_valid, busy, in_ready}, 32'd1);
    check("bp_dout_kept", d_out, held);
    sb.push_back(model(1'b1, 5'd3, 32'hF000_0010));
    tick();
    in_valid = 1'b0;
    check("bp_taken", {30'd0, busy, in_ready}, 32'd2);
    wait_done(5);
    pop_check("bp_new");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset on the third SHIFT cycle
    wait_ready();
    in_valid = 1'b1;
    sh_dir   = 1'b0;
    sh_amt   = 5'd5;
    d_in     = 32'hCAFE_F00D;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_status", {29'd0, out_valid, busy, in_ready}, 32'd1);
    check("mid_rst_dout", d_out, 32'h0);
    zl = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) zl++;
    end
    check("mid_rst_no_valid", 32'(zl), 32'd0);

    // fast zero path on the FAST_ZERO instance
    z_in_valid = 1'b1;
    sh_dir     = 1'b0;
    sh_amt     = 5'd0;
    d_in       = 32'hDEAD_BEEF;
    tick();
    z_in_valid = 1'b0;
    scramble();
    check("fz_valid_next", {31'd0, z_out_valid}, 32'd1);
    check("fz_dout", z_d_out, 32'hDEAD_BEEF);
    z_out_ready = 1'b1;
    tick();
    z_out_ready = 1'b0;
    check("fz_idle", {29'd0, z_out_valid, z_busy, z_in_ready}, 32'd1);
    z_in_valid = 1'b1;
    sh_dir     = 1'b1;
    sh_amt     = 5'd1;
    d_in       = 32'h8000_0000;
    tick();
    z_in_valid = 1'b0;
    zl = 0;
    while (!z_out_valid && zl < 20) begin
      tick();
      zl++;
    end
    check("fz_nz_lat", 32'(zl), 32'd5);
    check("fz_nz_dout", z_d_out, 32'hC000_0000);
    z_out_ready = 1'b1;
    tick();
    z_out_ready = 1'b0;

    // random sweep
    for (int n = 0; n < 1000; n++) begin
      run_req("rnd", 1'($urandom), 5'($urandom), $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_seq_ctrl.md
SHIFTER_SEQ_CTRL -- requirements
Module: shifter_seq_ctrl

Interface
REQ-001 The block SHALL have parameter FAST_ZERO, default 0: when 1, a request with SH_AMT==0 bypasses the SHIFT state.
REQ-002 The block SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port IN_VALID, input, 1 bit: request present.
REQ-005 The block SHALL have port IN_READY, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port SH_DIR, input, 1 bit: 1 = shift right (arithmetic), 0 = shift left (logical).
REQ-007 The block SHALL have port SH_AMT, input, 5 bits: shift amount 0..31.
REQ-008 The block SHALL have port D_IN, input, 32 bits: operand.
REQ-009 The block SHALL have port OUT_VALID, output, 1 bit: D_OUT holds a finished result.
REQ-010 The block SHALL have port OUT_READY, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have port D_OUT, output, 32 bits: registered result.
REQ-012 The block SHALL have port BUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT and DONE; IN_READY = (state==IDLE); OUT_VALID = (state==DONE).
REQ-014 IDLE: on a rising edge with IN_VALID&IN_READY, the block SHALL capture D_IN into the working register and latch SH_DIR/SH_AMT, clear stage counter k to 0, and enter SHIFT.
REQ-015 After capture, the block SHALL ignore all changes on SH_DIR, SH_AMT and D_IN until it returns to IDLE.
REQ-016 SHIFT: each cycle the block SHALL process stage k: if latched SH_AMT[k]==1, shift the working register by 2^k; otherwise hold it. k increments by 1 each cycle.
REQ-017 For a left stage, the block SHALL fill the vacated 2^k LSBs with 0 and discard the bits shifted out of the MSB end.
REQ-018 For a right stage, the block SHALL fill the vacated 2^k MSBs with the current bit 31 (sign replication) and discard the bits shifted out of the LSB end.
REQ-019 On the edge that processes k==4, the block SHALL enter DONE; latency from the capture edge to OUT_VALID high SHALL be exactly 5 cycles, independent of the SH_AMT value (FAST_ZERO=0).
REQ-020 When FAST_ZERO==1 and the captured SH_AMT==0, the block SHALL go from IDLE directly to DONE with D_OUT=D_IN, giving OUT_VALID 1 cycle after capture.
REQ-021 The result SHALL equal a single shift by SH_AMT: left = D_IN<<SH_AMT; right = arithmetic D_IN>>>SH_AMT; SH_AMT==0 gives D_IN.
REQ-022 DONE: the block SHALL hold D_OUT stable and OUT_VALID high until an edge with OUT_READY==1, then enter IDLE on that edge.
REQ-023 While not in IDLE, the block SHALL neither accept nor queue an IN_VALID; the next request is accepted no earlier than the cycle after the DONE->IDLE edge.
REQ-024 D_OUT SHALL be driven from the working register and change only on capture or on SHIFT edges.

Reset
REQ-025 On an edge with RST==1, the block SHALL enter IDLE and clear the stage counter and the working register/D_OUT to 0x0000_0000, so that OUT_VALID=0, BUSY=0 and IN_READY=1 after the edge.
REQ-026 RST SHALL take priority over every other input in any state; an in-flight operation SHALL be abandoned with no OUT_VALID pulse.

Verification
REQ-027 The bench SHALL cover a left shift: SH_DIR=0, SH_AMT=31, D_IN=0x0000_0001 -> D_OUT=0x8000_0000, OUT_VALID exactly 5 cycles after capture.
REQ-028 The bench SHALL cover an arithmetic right shift: SH_DIR=1, SH_AMT=4, D_IN=0x8000_0000 -> D_OUT=0xF800_0000; and SH_DIR=1, SH_AMT=31, D_IN=0x7FFF_FFFF -> D_OUT=0x0000_0000.
REQ-029 The bench SHALL cover backpressure: hold OUT_READY=0 for 3 cycles in DONE while pulsing IN_VALID with new data -> D_OUT stable, IN_READY=0, new request not taken; OUT_READY=1 -> IDLE next edge, request accepted the following cycle.
REQ-030 The bench SHALL cover reset mid-operation: assert RST on the third SHIFT cycle -> next edge IDLE, D_OUT=0, BUSY=0, no OUT_VALID.
REQ-031 The bench SHALL cover the zero-amount path: FAST_ZERO=1, SH_AMT=0, D_IN=0xDEAD_BEEF -> OUT_VALID 1 cycle after capture, D_OUT=0xDEAD_BEEF; with FAST_ZERO=0 the same request SHALL take 5 cycles.
REQ-032 The bench SHALL cover random sweeps: 1000 random (SH_DIR, SH_AMT, D_IN) requests with random OUT_READY, each result matching REQ-021.
